// File: rtl/lint2apb_bridge_pkg.sv
// lint2apb_bridge shared types and constants.
// FSM state encoding, full byte-enable mask, error read data.
package lint2apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0]  BE_FULL   = 4'hF;
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/lint2apb_bridge_if.sv
// Bus bundles for lint2apb_bridge: lint_if (request/grant/rvalid
// data port) and apb_if (APB3); master/slave modports on each.
interface lint_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req_i;
  logic          data_gnt_o;
  logic [AW-1:0] data_addr_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i,
    output data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o,
    input  data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i,
    input  data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o,
    output data_rdata_o, data_err_o
  );
endinterface

interface apb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pwrite_o;
  logic          psel_o;
  logic          penable_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;
  logic          pslverr_i;

  modport master (
    output paddr_o, pwdata_o, pwrite_o,
    output psel_o, penable_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  paddr_o, pwdata_o, pwrite_o,
    input  psel_o, penable_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/lint2apb_bridge_timeout_cnt.sv
// Counts ACCESS wait cycles; expired flags the wait cycle that hits
// the limit. Ports: clk_i, rst_i, clear, enable, expired.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk_i, rst_i, clear, enable};
    assign expired   = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i || clear) cnt <= '0;
      else if (enable)    cnt <= cnt + CW'(1);
    end

    // Fires on the wait cycle that brings the count to the limit,
    // so the bus is released after exactly TIMEOUT_CYCLES waits.
    assign expired = enable && (cnt == LAST);
  end

endmodule

// File: rtl/lint2apb_bridge.sv
// Request/grant/rvalid to APB3 master bridge, one transfer in flight.
// Ports: clk_i, rst_i, lint (lint_if.slave), apb (apb_if.master).
module lint2apb_bridge #(
  parameter int          APB_ADDR_WIDTH = 32,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic   clk_i,
  input logic   rst_i,
  lint_if.slave lint,
  apb_if.master apb
);
  import lint2apb_pkg::*;

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;

  state_e        state, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic          psel_q, psel_d;
  logic          pen_q, pen_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic cnt_clr;
  logic cnt_en;
  logic expired;
  logic unused_addr;

  assign unused_addr = ^lint.data_addr_i[1:0];

  assign lint.data_gnt_o = lint.data_req_i & (state == IDLE);

  assign cnt_en  = (state == ACCESS) & ~apb.pready_i;
  assign cnt_clr = (state == IDLE) & (state_d == SETUP);

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .expired(expired)
  );

  always_comb begin
    state_d  = state;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    psel_d   = 1'b0;
    pen_d    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (lint.data_req_i) begin
          paddr_d  = {lint.data_addr_i[AW-1:2], 2'b00};
          pwrite_d = lint.data_we_i;
          pwdata_d = lint.data_wdata_i;
          // Sub-word writes are refused without touching the bus.
          if (lint.data_we_i && lint.data_be_i != BE_FULL) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = SETUP;
            psel_d  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        psel_d  = 1'b1;
        pen_d   = 1'b1;
      end
      ACCESS: begin
        if (apb.pready_i) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : apb.prdata_i;
          err_d    = apb.pslverr_i;
        end else if (expired) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = ERR_RDATA;
          err_d    = 1'b1;
        end else begin
          psel_d = 1'b1;
          pen_d  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign apb.paddr_o   = paddr_q;
  assign apb.pwdata_o  = pwdata_q;
  assign apb.pwrite_o  = pwrite_q;
  assign apb.psel_o    = psel_q;
  assign apb.penable_o = pen_q;

  assign lint.data_rvalid_o = rvalid_q;
  assign lint.data_rdata_o  = rdata_q;
  assign lint.data_err_o    = err_q;

endmodule

// File: doc/lint2apb_bridge.md
Name: lint2apb_bridge

Overview:
- Converts the core/debug data-side request/grant/rvalid interface into APB3 master transfers.
- Sits directly upstream of the SoC peripheral APB bus wrapper; its APB master port drives that wrapper's APB slave port.
- Handles one outstanding transfer at a time, APB wait states, PSLVERR propagation and a bus-hang timeout.

Parameters:
- APB_ADDR_WIDTH, 32, width of the address on both sides.
- APB_DATA_WIDTH, 32, width of the data on both sides; fixed at 32, byte enables are 4 bits.
- TIMEOUT_CYCLES, 256, maximum number of ACCESS cycles without PREADY before the bridge aborts; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- data_req_i  in  1  request valid
- data_gnt_o  out  1  request accepted
- data_addr_i  in  APB_ADDR_WIDTH  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  APB_DATA_WIDTH  write data
- data_rvalid_o  out  1  response valid, one cycle
- data_rdata_o  out  APB_DATA_WIDTH  read data
- data_err_o  out  1  response error, qualified by rvalid
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  APB_DATA_WIDTH  APB write data
- pwrite_o  out  1  APB direction
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  APB_DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Clocking and reset: single clock clk_i. rst_i is synchronous and active-high.
- Reset values: all registered outputs are 0, state is IDLE and the timeout counter is 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Grant: data_gnt_o = data_req_i & (state==IDLE). It is combinational and is never asserted in any other state.
- IDLE, on grant: capture the request.
  - paddr_o <= {addr[W-1:2], 2'b00}; the address is word-aligned and low bits are ignored.
  - Capture pwrite_o and pwdata_o.
  - Full-word write (be==4'hF) or any read: go to SETUP. Read byte enables are ignored; a full word is always read.
  - Partial write (be!=4'hF): no APB transfer. Go to RESP with err=1.
- SETUP: psel_o=1, penable_o=0, lasting exactly one cycle. Then go to ACCESS.
- ACCESS: psel_o=1, penable_o=1; paddr, pwdata and pwrite are held stable.
  - When pready_i=1: latch prdata_i (reads only; writes return 0), latch err=pslverr_i, deassert psel/penable at the next edge and go to RESP.
  - The timeout counter increments on each ACCESS cycle with pready_i=0.
  - When the counter reaches TIMEOUT_CYCLES (nonzero): deassert psel/penable, rdata=0, err=1, go to RESP.
  - A pready_i arriving after an abort is ignored.
- RESP: data_rvalid_o=1 for exactly one cycle, together with data_rdata_o and data_err_o. Then go to IDLE.
  - data_rdata_o and data_err_o return to 0 when rvalid is low.
- Latency: a zero-wait-state transfer gives grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2 and rvalid in cycle 3. Each APB wait state adds 1 cycle. Best throughput is one transfer per 4 cycles.
- Back-to-back: a request held high through RESP is granted in the following IDLE cycle.
- Simultaneous events:
  - pready_i=1 in the same cycle the counter reaches the limit: pready wins and the transfer completes normally.
  - rst_i overrides all other inputs.
- Reset mid-operation: the FSM returns to IDLE at the next edge. psel and penable drop, and any pending response is discarded (no rvalid is emitted).
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter clears on entry to SETUP.

Decomposition:
- lint2apb_pkg contains:
  - the state enum typedef (IDLE/SETUP/ACCESS/RESP, 2 bits);
  - the localparam BE_FULL=4'hF;
  - the error read-data constant (0).
- Sub-module apb_timeout_cnt: parameter TIMEOUT_CYCLES; ports clear, enable and expired.
  - With TIMEOUT_CYCLES=0, expired is tied to 0.

Test Plan:
- Read 0x1A10_0006, pready=1 in the first ACCESS cycle, prdata=0x1234_5678 -> gnt in cycle 0; paddr=0x1A10_0004 and psel=1 in cycle 1; penable=1 in cycle 2; rvalid in cycle 3 with rdata=0x1234_5678 and err=0.
- Write 0xCAFE_F00D to 0x1A10_1000, be=F, 2 wait states -> penable high for 3 cycles with pwrite=1 and pwdata stable; rvalid in cycle 5 with err=0 and rdata=0.
- Read with pready=1 and pslverr=1 -> rvalid in cycle 3 with err=1.
- Write with be=4'h3 -> psel never asserted; rvalid in cycle 1 with err=1.
- TIMEOUT_CYCLES=16, pready held 0 -> psel drops after 16 ACCESS cycles; rvalid with err=1 and rdata=0; a later pready pulse is ignored; the next request is served normally.
- rst_i asserted during ACCESS -> psel=penable=0 and state IDLE at the next edge with no rvalid. Requests held high across RESP -> the second gnt comes exactly 1 cycle after rvalid.
